// File: rtl/nf_dispatch_1t2_if.sv
// Handshake bundle for the 1-to-2 non-fast-pattern rule dispatcher.
// A rule word is {last, data}: the MSB carries rule_nf_t.last.
interface nf_dispatch_1t2_if #(
  parameter int DATA_W = 32
);
  localparam int RULE_NF_WIDTH = DATA_W + 1;

  logic [RULE_NF_WIDTH-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [RULE_NF_WIDTH-1:0] out_data_0;
  logic                     out_valid_0;
  logic                     out_ready_0;
  logic [RULE_NF_WIDTH-1:0] out_data_1;
  logic                     out_valid_1;
  logic                     out_ready_1;

  modport master (
    output in_data, in_valid, out_ready_0, out_ready_1,
    input  in_ready, out_data_0, out_valid_0, out_data_1, out_valid_1
  );

  modport slave (
    input  in_data, in_valid, out_ready_0, out_ready_1,
    output in_ready, out_data_0, out_valid_0, out_data_1, out_valid_1
  );
endinterface

// File: rtl/nf_dispatch_1t2.sv
// Spreads non-last rules round-robin over two lane FIFOs and broadcasts each last rule to both.
// Optional statistics counters are enabled by defining NF_DISPATCH_STATS_EN.
module nf_dispatch_1t2 #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic clk,
  input  logic rst_n,
  nf_dispatch_1t2_if.slave bus
`ifdef NF_DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_rules_0,
  output logic [CNT_W-1:0] stat_rules_1,
  output logic [CNT_W-1:0] stat_pkts
`endif
);

  localparam int RW = DATA_W + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] HOLD_LAST = 1'b1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (CNT_W < 1)) begin : g_bad_params
    $error("nf_dispatch_1t2: FIFO_DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
  end

  logic [RW-1:0] mem [2][FIFO_DEPTH];
  logic [AW-1:0] rd_ptr [2];
  logic [AW-1:0] wr_ptr [2];
  logic [CW-1:0] count  [2];

  logic [0:0] state;
  logic       rr_ptr;
  logic       lane;
  logic       in_last;
  logic       need_both;
  logic       in_ready;
  logic       xfer;
  logic [1:0] space;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;

  // A last rule, or a dispatcher still holding one, needs a free slot in both lanes.
  always_comb begin
    in_last   = bus.in_data[RW-1];
    space[0]  = (count[0] != FULL);
    space[1]  = (count[1] != FULL);
    valid[0]  = rst_n & (count[0] != '0);
    valid[1]  = rst_n & (count[1] != '0);
    pop[0]    = valid[0] & bus.out_ready_0;
    pop[1]    = valid[1] & bus.out_ready_1;
    need_both = in_last | (state == HOLD_LAST);
    in_ready  = rst_n & (need_both ? (space[0] & space[1]) : (space[0] | space[1]));
    xfer      = bus.in_valid & in_ready;
    lane      = space[rr_ptr] ? rr_ptr : ~rr_ptr;
    push[0]   = xfer & (in_last | ~lane);
    push[1]   = xfer & (in_last | lane);
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid_0 = valid[0];
  assign bus.out_valid_1 = valid[1];
  assign bus.out_data_0  = rst_n ? mem[0][rd_ptr[0]] : '0;
  assign bus.out_data_1  = rst_n ? mem[1][rd_ptr[1]] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      rr_ptr <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      case (state)
        RUN:       if (bus.in_valid & in_last & ~(space[0] & space[1])) state <= HOLD_LAST;
        HOLD_LAST: if (xfer & in_last) state <= RUN;
        default:   state <= RUN;
      endcase

      // Packets restart on lane 0 so both lanes line up at every last rule.
      if (xfer) rr_ptr <= in_last ? 1'b0 : ~lane;

      for (int k = 0; k < 2; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
        if (push[k] & ~pop[k])      count[k] <= count[k] + CW'(1);
        else if (~push[k] & pop[k]) count[k] <= count[k] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= bus.in_data;
    end
  end

`ifdef NF_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rules_0 <= '0;
      stat_rules_1 <= '0;
      stat_pkts    <= '0;
    end else begin
      if (xfer & ~in_last & ~lane) stat_rules_0 <= stat_rules_0 + CNT_W'(1);
      if (xfer & ~in_last & lane)  stat_rules_1 <= stat_rules_1 + CNT_W'(1);
      if (xfer & in_last)          stat_pkts    <= stat_pkts + CNT_W'(1);
    end
  end
`endif

endmodule
